// File: rtl/synapse_delay_scheduler_if.sv
// Handshake and configuration bundle for the synapse delay scheduler.
// The master side drives spikes, delay writes and out_ready; the slave side is the scheduler.
interface synapse_delay_scheduler_if #(
    parameter int N_SYN   = 4,
    parameter int DELAY_W = 4
);
    localparam int ID_W = $clog2(N_SYN);

    logic [N_SYN-1:0]   spike_in;
    logic               cfg_we;
    logic [ID_W-1:0]    cfg_addr;
    logic [DELAY_W-1:0] cfg_delay;
    logic               out_valid;
    logic [ID_W-1:0]    out_id;
    logic               out_ready;
    logic [N_SYN-1:0]   busy;
    logic [N_SYN-1:0]   spike_drop;

    modport master (
        output spike_in, cfg_we, cfg_addr, cfg_delay, out_ready,
        input  out_valid, out_id, busy, spike_drop
    );

    modport slave (
        input  spike_in, cfg_we, cfg_addr, cfg_delay, out_ready,
        output out_valid, out_id, busy, spike_drop
    );
endinterface

// File: rtl/synapse_delay_scheduler.sv
// Per-synapse programmable spike delay with a round-robin output arbiter.
// Each synapse runs IDLE -> WAIT (count down) -> PEND (wait for grant) -> IDLE.
module synapse_delay_scheduler #(
    parameter int N_SYN   = 4,
    parameter int DELAY_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    synapse_delay_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(N_SYN);

    generate
        if (N_SYN < 2) begin : g_bad_n_syn
            $error("synapse_delay_scheduler: N_SYN must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PEND = 2'd2
    } syn_state_t;

    // A programmed delay of 0 behaves like 1, so the load value is max(d,1)-1.
    function automatic logic [DELAY_W-1:0] load_value(input logic [DELAY_W-1:0] d);
        logic [DELAY_W-1:0] v;
        if (d == {DELAY_W{1'b0}}) begin
            v = {DELAY_W{1'b0}};
        end else begin
            v = d - {{(DELAY_W-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    logic [1:0]         rst_sync_r;
    logic               rst_int_n_s;
    syn_state_t         state_r     [N_SYN];
    syn_state_t         state_nxt_s [N_SYN];
    logic [DELAY_W-1:0] cnt_r       [N_SYN];
    logic [DELAY_W-1:0] cnt_nxt_s   [N_SYN];
    logic [DELAY_W-1:0] delay_r     [N_SYN];
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    rr_ptr_nxt_s;
    logic [N_SYN-1:0]   pend_s;
    logic [N_SYN-1:0]   busy_s;
    logic [N_SYN-1:0]   grant_s;
    logic               out_valid_s;
    logic [ID_W-1:0]    out_id_s;
    logic               handshake_s;

    // Reset asserts immediately and releases two clean edges later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    generate
        for (genvar g = 0; g < N_SYN; g++) begin : g_decode
            assign pend_s[g]  = (state_r[g] == ST_PEND);
            assign busy_s[g]  = (state_r[g] != ST_IDLE);
            assign grant_s[g] = handshake_s && (out_id_s == ID_W'(g));
        end
    endgenerate

    // Round-robin pick: first PEND synapse at or after rr_ptr, wrapping
    always_comb begin
        int  idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        out_id_s  = {ID_W{1'b0}};
        for (int j = 0; j < N_SYN; j++) begin
            idx = int'(rr_ptr_r) + j;
            if (idx >= N_SYN) begin
                idx = idx - N_SYN;
            end else begin
                idx = idx;
            end
            if (!found && pend_s[idx]) begin
                found    = 1'b1;
                out_id_s = ID_W'(idx);
            end else begin
                found    = found;
            end
        end
    end

    assign out_valid_s = |pend_s;
    assign handshake_s = out_valid_s && bus.out_ready;

    // Pointer advances past the granted synapse only on a handshake
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        if (handshake_s) begin
            if (out_id_s == ID_W'(N_SYN - 1)) begin
                rr_ptr_nxt_s = {ID_W{1'b0}};
            end else begin
                rr_ptr_nxt_s = out_id_s + {{(ID_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Per-synapse next state and counter
    always_comb begin
        for (int i = 0; i < N_SYN; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (bus.spike_in[i]) begin
                        state_nxt_s[i] = ST_WAIT;
                        cnt_nxt_s[i]   = load_value(delay_r[i]);
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r[i] == {DELAY_W{1'b0}}) begin
                        state_nxt_s[i] = ST_PEND;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - {{(DELAY_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PEND: begin
                    if (grant_s[i]) begin
                        state_nxt_s[i] = ST_IDLE;
                    end else begin
                        state_nxt_s[i] = ST_PEND;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                    cnt_nxt_s[i]   = {DELAY_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and arbiter pointer registers
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            for (int i = 0; i < N_SYN; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= {DELAY_W{1'b0}};
            end
            rr_ptr_r <= {ID_W{1'b0}};
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Delay registers; a same-cycle spike already loaded from the old value
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            for (int i = 0; i < N_SYN; i++) begin
                delay_r[i] <= {{(DELAY_W-1){1'b0}}, 1'b1};
            end
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < N_SYN)) begin
            delay_r[bus.cfg_addr] <= bus.cfg_delay;
        end
    end

    assign bus.out_valid  = out_valid_s;
    assign bus.out_id     = out_id_s;
    assign bus.busy       = busy_s;
    assign bus.spike_drop = bus.spike_in & busy_s;

endmodule

// File: tb/tb_synapse_delay_scheduler.sv
// Scoreboard bench: a timestamp-based reference model predicts each cycle's outputs,
// and an independent monitor compares them against the scheduler on the falling edge.
module tb_synapse_delay_scheduler;
    localparam int N  = 4;
    localparam int DW = 4;

    typedef struct {
        logic       valid;
        logic [1:0] id;
        logic [3:0] busy;
        logic [3:0] drop;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    int   cyc;
    exp_t exp_q[$];

    bit   m_act [N];
    int   m_due [N];
    int   m_dly [N];
    int   m_rr;

    synapse_delay_scheduler_if #(.N_SYN(N), .DELAY_W(DW)) bus ();

    synapse_delay_scheduler #(.N_SYN(N), .DELAY_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act == want) begin
            passes++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0;
            m_due[i] = 0;
            m_dly[i] = 1;
        end
        m_rr = 0;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model past the edge
    task automatic model_cycle(input logic [3:0] sp, input logic we, input logic [1:0] a,
                               input logic [3:0] d, input logic rdy);
        exp_t e;
        bit   pend [N];
        bit   was  [N];
        int   idx;
        e.valid = 1'b0;
        e.id    = 2'd0;
        for (int i = 0; i < N; i++) begin
            was[i]    = m_act[i];
            pend[i]   = m_act[i] && (cyc >= m_due[i]);
            e.busy[i] = m_act[i];
            e.drop[i] = sp[i] && m_act[i];
        end
        for (int j = 0; j < N; j++) begin
            idx = (m_rr + j) % N;
            if (pend[idx] && !e.valid) begin
                e.valid = 1'b1;
                e.id    = 2'(idx);
            end
        end
        exp_q.push_back(e);
        if (e.valid && rdy) begin
            m_act[e.id] = 1'b0;
            m_rr        = (int'(e.id) + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (sp[i] && !was[i]) begin
                m_act[i] = 1'b1;
                m_due[i] = cyc + 1 + ((m_dly[i] == 0) ? 1 : m_dly[i]);
            end
        end
        if (we) m_dly[a] = int'(d);
    endtask

    task automatic step(input logic [3:0] sp, input logic we, input logic [1:0] a,
                        input logic [3:0] d, input logic rdy);
        bus.spike_in  = sp;
        bus.cfg_we    = we;
        bus.cfg_addr  = a;
        bus.cfg_delay = d;
        bus.out_ready = rdy;
        model_cycle(sp, we, a, d, rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(4'b0000, 1'b0, 2'd0, 4'd0, rdy);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        step(4'b0000, 1'b1, a, d, 1'b1);
    endtask

    // Monitor: compare whatever the scheduler presents against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", int'(bus.out_valid), int'(e.valid));
            if (e.valid) chk("out_id", int'(bus.out_id), int'(e.id));
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("spike_drop", int'(bus.spike_drop), int'(e.drop));
        end
    end

    initial begin
        checks = 0;
        passes = 0;
        cyc    = 0;
        model_reset();
        reset         = 1'b0;
        bus.spike_in  = 4'b1111;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_delay = 4'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_spike_drop", int'(bus.spike_drop), 0);
        bus.spike_in = 4'b0000;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Delay 1 (reset value) and delay 0 both give one cycle of latency
        step(4'b0001, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(3, 1'b1);
        wr(2'd0, 4'd0);
        step(4'b0001, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(3, 1'b1);

        // Delay 5 on synapse 2
        wr(2'd2, 4'd5);
        step(4'b0100, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(8, 1'b1);

        // All delays 3, simultaneous burst, then a 1/3 pair
        for (int i = 0; i < N; i++) wr(2'(i), 4'd3);
        step(4'b1111, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(8, 1'b1);
        step(4'b1010, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(7, 1'b1);

        // Stall with synapse 1 pending; re-spike during the hold is dropped
        wr(2'd1, 4'd1);
        step(4'b0010, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(2, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Reprogramming delay mid-flight leaves the running count alone
        wr(2'd3, 4'd8);
        step(4'b1000, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(1, 1'b1);
        wr(2'd3, 4'd2);
        idle(8, 1'b1);
        step(4'b1000, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(4, 1'b1);

        // Spike and write to the same synapse in one cycle uses the old delay
        step(4'b0001, 1'b1, 2'd0, 4'd6, 1'b1);
        idle(4, 1'b1);
        step(4'b0001, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(8, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] sp;
            for (int i = 0; i < N; i++) sp[i] = ($urandom_range(0, 5) == 0);
            step(sp, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 9)), ($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);

        // Reset with two synapses waiting and one pending
        wr(2'd0, 4'd6);
        wr(2'd1, 4'd6);
        wr(2'd2, 4'd1);
        step(4'b0111, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(3, 1'b0);
        bus.spike_in = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_spike_drop", int'(bus.spike_drop), 0);
        model_reset();
        bus.spike_in = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(6, 1'b1);
        for (int i = 0; i < N; i++) begin
            step(4'(1 << i), 1'b0, 2'd0, 4'd0, 1'b1);
            idle(3, 1'b1);
        end
        idle(2, 1'b1);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
